usbdev_wb_arbiter: RTL
======================

// Module: usbdev_wb_arbiter
// PURPOSE
// - Two-master Wishbone arbiter in front of the single Wishbone slave port of the USB device core (ctrl clock domain).
// - Master 0 is the external pin-driven host; master 1 is the on-chip init/poll sequencer.
// - Round-robin ownership, held for the owner's whole CYC; response routed to the owner only.
// - Optional stall watchdog aborts a hung slave access.
// PARAMETERS
// - ADDR_W   14   Wishbone address width (word address)
// - DATA_W   32   Wishbone data width; SEL width = DATA_W/8
// - TIMEOUT  255  watchdog limit in clk cycles; used only with USBDEV_WB_TIMEOUT_EN; range 1..65535
// PORTS
// - clk        in   1        ctrl-domain clock
// - rst        in   1        async reset, active high
// - mN_cyc     in   1        master N (N=0,1) bus cycle request
// - mN_stb     in   1        master N strobe
// - mN_we      in   1        master N write enable
// - mN_adr     in   ADDR_W   master N address
// - mN_dat_w   in   DATA_W   master N write data
// - mN_sel     in   DATA_W/8 master N byte selects
// - mN_ack     out  1        master N acknowledge
// - mN_err     out  1        master N watchdog error
// - mN_dat_r   out  DATA_W   master N read data
// - s_cyc/s_stb/s_we  out  1 each  to slave
// - s_adr      out  ADDR_W   to slave
// - s_dat_w    out  DATA_W   to slave
// - s_sel      out  DATA_W/8 to slave
// - s_ack      in   1        from slave
// - s_dat_r    in   DATA_W   from slave
// - grant      out  2        one-hot owner (bit N = master N); 2'b00 = none
// BEHAVIOUR
// - Registered state: IDLE, OWN0, OWN1, ABORT, plus last_owner (1 bit).
// - Reset: state=IDLE, last_owner=1 (m0 wins first tie); all outputs 0; watchdog count=0.
// - IDLE: m0_cyc only -> OWN0; m1_cyc only -> OWN1; both -> master != last_owner; neither -> stay.
//   - Grant latency: 1 clk from CYC rise to s_cyc.
// - OWNn: last_owner<=n on entry; stay while mn_cyc=1.
//   - mn_cyc=0 with other cyc=1 -> direct handoff to other OWN; else -> IDLE.
// - Slave mux is combinational from state. When owned, s_* = owner's m_*.
//   - IDLE/ABORT: s_cyc=s_stb=s_we=0, s_adr=s_dat_w=s_sel=0.
// - Owner: m_ack = s_ack & owner_stb; m_dat_r = s_dat_r.
//   - Non-owner: ack=0, err=0, dat_r=0.
// - s_cyc follows the owner's cyc combinationally, so a dropped cyc ends the slave cycle in that clk.
// - Requests from the non-owner are ignored, not queued; the master must hold cyc until granted.
// - grant mirrors state: OWN0=01, OWN1=10, else 00.
// - Async rst mid-transfer: state and outputs clear immediately; in-flight ack is discarded.
// CONFIGURATION
// - USBDEV_WB_TIMEOUT_EN defined:
//   - Counter of width $clog2(TIMEOUT+1) increments each clk with owner stb=1 and s_ack=0.
//   - Count clears on s_ack, owner stb=0, or state change.
//   - When count reaches TIMEOUT: owner mN_err=1 for 1 clk, state->ABORT; slave sees cyc=0 for >=1 clk.
//   - ABORT -> IDLE next clk; last_owner is kept.
//   - s_ack in the same clk as the limit: ack wins, no err.
// - USBDEV_WB_TIMEOUT_EN undefined: no counter or ABORT logic; mN_err tied 0; ownership never revoked.
// TESTING
// - Reset release, m0 read adr=0x0010, slave acks after 3 clks with 0xDEADBEEF.
//   -> s_cyc rises 1 clk after m0_cyc; m0_ack 1 clk with dat 0xDEADBEEF; m1_ack=0.
// - m0_cyc and m1_cyc rise together from reset.
//   -> grant=01 first; after m0 drops cyc, grant=10 next clk with no IDLE gap.
// - Both masters hold cyc, 4 back-to-back single transfers each.
//   -> grants alternate 01,10,01,10; no master served twice in a row.
// - m1 owns, write 0x12345678 sel=4'b0011; m0 raises cyc mid-transfer.
//   -> s_dat_w/s_sel stay m1's until m1 drops cyc; m0 sees no ack.
// - TIMEOUT_EN, TIMEOUT=8, slave never acks.
//   -> m0_err pulses at 8th stalled clk; s_cyc low next clk; grant=00; IDLE.
//   - Same bench, ack on the 8th clk -> ack, no err.
// - Async rst pulse mid-write.
//   -> grant=00, s_cyc=0 immediately; after release m0 is granted first on a tie.

Source files
------------

// File: rtl/usbdev_wb_arbiter_if.sv
// usbdev_wb_arbiter_if
// One Wishbone link between a bus master and a bus slave.
//   master modport : drives cyc/stb/we/adr/dat_w/sel, receives ack/err/dat_r
//   slave  modport : receives cyc/stb/we/adr/dat_w/sel, drives ack/err/dat_r
// Parameters: ADDR_W (word address width), DATA_W (data width, SEL = DATA_W/8).
interface usbdev_wb_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] dat_w;
  logic [SEL_W-1:0]  sel;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] dat_r;

  modport master (output cyc, stb, we, adr, dat_w, sel,
                  input  ack, err, dat_r);
  modport slave  (input  cyc, stb, we, adr, dat_w, sel,
                  output ack, err, dat_r);
endinterface

// File: rtl/usbdev_wb_arbiter.sv
// usbdev_wb_arbiter
// Two-master Wishbone arbiter in front of the USB device core's single slave
// port (ctrl clock domain). Master 0 is the external host, master 1 the
// on-chip init/poll sequencer. Ownership is round-robin and held for the
// owner's whole CYC; responses are routed to the owner only.
// Ports:
//   clk, rst  : ctrl clock, asynchronous active-high reset
//   m0, m1    : master links (slave modport of usbdev_wb_arbiter_if)
//   s         : link to the USB core slave port (master modport)
//   grant     : one-hot owner, bit N = master N, 2'b00 = no owner
// Optional feature: define USBDEV_WB_TIMEOUT_EN to enable the stall watchdog
// that aborts an access after TIMEOUT stalled clocks (owner gets a 1-clk err).
module usbdev_wb_arbiter #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  usbdev_wb_arbiter_if.slave   m0,
  usbdev_wb_arbiter_if.slave   m1,
  usbdev_wb_arbiter_if.master  s,
  output logic [1:0]           grant
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OWN0  = 2'd1;
  localparam logic [1:0] S_OWN1  = 2'd2;
  localparam logic [1:0] S_ABORT = 2'd3;

  logic [1:0] state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic       own0, own1;
  logic       owner_stb;
  logic       wd_err;

  assign own0      = (state_q == S_OWN0);
  assign own1      = (state_q == S_OWN1);
  assign owner_stb = (own0 & m0.stb) | (own1 & m1.stb);
  assign grant     = {own1, own0};

  // The slave never drives err toward the arbiter; TIMEOUT is only consumed
  // by the watchdog build.
  logic unused_ok;
  assign unused_ok = s.err | (TIMEOUT == 0);

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        // Tie goes to whoever did not own the bus last.
        if (m0.cyc && m1.cyc) state_d = last_owner_q ? S_OWN0 : S_OWN1;
        else if (m0.cyc)      state_d = S_OWN0;
        else if (m1.cyc)      state_d = S_OWN1;
      end
      S_OWN0: begin
        if (wd_err)       state_d = S_ABORT;
        else if (!m0.cyc) state_d = m1.cyc ? S_OWN1 : S_IDLE;
      end
      S_OWN1: begin
        if (wd_err)       state_d = S_ABORT;
        else if (!m1.cyc) state_d = m0.cyc ? S_OWN0 : S_IDLE;
      end
      default: state_d = S_IDLE;  // ABORT lasts exactly one clock
    endcase

    last_owner_d = last_owner_q;
    if (state_d == S_OWN0)      last_owner_d = 1'b0;
    else if (state_d == S_OWN1) last_owner_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_owner_q <= 1'b1;   // m0 wins the first tie
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // ------------------------------------------------------------ watchdog
`ifdef USBDEV_WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // err fires during the TIMEOUT-th stalled clock, i.e. when TIMEOUT-1
  // stalled clocks have already been counted.
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             stall;

  assign stall  = (own0 | own1) & owner_stb & ~s.ack;
  assign wd_err = stall & (wd_cnt_q == LIMIT);  // s_ack in same clk wins

  always_comb begin
    wd_cnt_d = '0;
    if (stall && (state_d == state_q)) wd_cnt_d = wd_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wd_cnt_q <= '0;
    else     wd_cnt_q <= wd_cnt_d;
  end
`else
  assign wd_err = 1'b0;
`endif

  // ---------------------------------------------------------- slave mux
  // Purely combinational from state: a dropped owner cyc ends the slave
  // cycle in the same clock, and IDLE/ABORT present an all-zero bus.
  always_comb begin
    s.cyc   = 1'b0;
    s.stb   = 1'b0;
    s.we    = 1'b0;
    s.adr   = '0;
    s.dat_w = '0;
    s.sel   = '0;
    if (own0) begin
      s.cyc   = m0.cyc;
      s.stb   = m0.stb;
      s.we    = m0.we;
      s.adr   = m0.adr;
      s.dat_w = m0.dat_w;
      s.sel   = m0.sel;
    end else if (own1) begin
      s.cyc   = m1.cyc;
      s.stb   = m1.stb;
      s.we    = m1.we;
      s.adr   = m1.adr;
      s.dat_w = m1.dat_w;
      s.sel   = m1.sel;
    end
  end

  // ------------------------------------------------------- response route
  assign m0.ack   = own0 & s.ack & m0.stb;
  assign m1.ack   = own1 & s.ack & m1.stb;
  assign m0.err   = own0 & wd_err;
  assign m1.err   = own1 & wd_err;
  assign m0.dat_r = own0 ? s.dat_r : '0;
  assign m1.dat_r = own1 ? s.dat_r : '0;

endmodule
